// File: rtl/solar_wb_regs_if.sv
// Wishbone classic bus bundle between the management SoC (master) and the
// solar monitor register block (slave). Signal names follow the Caravel
// wbs_* naming as seen from the slave.
interface solar_wb_regs_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/solar_wb_regs.sv
// Wishbone classic register window for the solar panel monitor.
// Holds control/threshold registers, a periodic sample timer that snapshots
// the 24-bit sensor bus, an undervoltage compare with a saturating fault
// counter, and a sticky maskable level interrupt.
//
// Handshake: a request is cyc & stb & window match. ack is a registered
// one-cycle pulse on the edge after the request; the initiator holds stb
// until it sees ack. Writes commit and read data is captured on that same
// edge; dat_o is zero whenever ack is low.
module solar_wb_regs #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE   = 32'h534C_5231,
    parameter logic [15:0] PERIOD_RST = 16'd1000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    solar_wb_regs_if.slave    wbs,
    input  logic [23:0]       sensor_i,
    output logic              irq_o
);

    localparam logic [5:0] IDX_ID     = 6'd0;
    localparam logic [5:0] IDX_CTRL   = 6'd1;
    localparam logic [5:0] IDX_SAMPLE = 6'd2;
    localparam logic [5:0] IDX_THRESH = 6'd3;
    localparam logic [5:0] IDX_STATUS = 6'd4;

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic [15:0] period_q, period_d;
    logic [11:0] thresh_q, thresh_d;
    logic [23:0] sample_q, sample_d;
    logic        valid_q, valid_d;
    logic        under_q, under_d;
    logic [15:0] under_cnt_q, under_cnt_d;
    logic [15:0] timer_q, timer_d;

    logic        hit;
    logic        access;
    logic        wr;
    logic [5:0]  reg_idx;
    logic [31:0] rdata;
    logic        tick;
    logic        under_hit;
    logic        clr_valid, clr_under, clr_cnt;

    // Bits of the bus that no register uses; kept to document that they are ignored.
    logic        unused_bits;
    assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[15:12]};

    assign hit       = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                       (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign access    = hit & ~ack_q;
    assign wr        = access & wbs.wbs_we_i;
    assign reg_idx   = wbs.wbs_adr_i[7:2];
    assign tick      = en_q & (timer_q == 16'd0);
    assign under_hit = tick & (sensor_i[11:0] < thresh_q);

    assign clr_valid = wr & (reg_idx == IDX_STATUS) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[0];
    assign clr_under = wr & (reg_idx == IDX_STATUS) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[1];
    assign clr_cnt   = wr & (reg_idx == IDX_STATUS) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[2];

    // Read mux over the register values as they stand before the ack edge.
    always_comb begin
        rdata = 32'h0;
        case (reg_idx)
            IDX_ID:     rdata = ID_VALUE;
            IDX_CTRL:   rdata = {period_q, 14'h0, irq_en_q, en_q};
            IDX_SAMPLE: rdata = {8'h0, sample_q};
            IDX_THRESH: rdata = {20'h0, thresh_q};
            IDX_STATUS: rdata = {under_cnt_q, 14'h0, under_q, valid_q};
            default:    rdata = 32'h0;
        endcase
    end

    // Next-state for bus response, writable registers, timer and status.
    always_comb begin
        ack_d       = access;
        dat_d       = (access & ~wbs.wbs_we_i) ? rdata : 32'h0;
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        period_d    = period_q;
        thresh_d    = thresh_q;
        sample_d    = sample_q;
        valid_d     = valid_q;
        under_d     = under_q;
        under_cnt_d = under_cnt_q;
        timer_d     = timer_q;

        if (wr && reg_idx == IDX_CTRL) begin
            if (wbs.wbs_sel_i[0]) begin
                en_d     = wbs.wbs_dat_i[0];
                irq_en_d = wbs.wbs_dat_i[1];
            end
            if (wbs.wbs_sel_i[2]) period_d[7:0]  = wbs.wbs_dat_i[23:16];
            if (wbs.wbs_sel_i[3]) period_d[15:8] = wbs.wbs_dat_i[31:24];
        end
        if (wr && reg_idx == IDX_THRESH) begin
            if (wbs.wbs_sel_i[0]) thresh_d[7:0]  = wbs.wbs_dat_i[7:0];
            if (wbs.wbs_sel_i[1]) thresh_d[11:8] = wbs.wbs_dat_i[11:8];
        end

        // A stopped timer tracks the incoming period so that the first tick
        // lands period+1 cycles after the edge that sets en.
        if (!en_q)        timer_d = period_d;
        else if (tick)    timer_d = period_q;
        else              timer_d = timer_q - 16'd1;

        // A tick setting a status bit wins over a same-edge clear of that bit.
        if (tick)           valid_d = 1'b1;
        else if (clr_valid) valid_d = 1'b0;

        if (under_hit)      under_d = 1'b1;
        else if (clr_under) under_d = 1'b0;

        if (under_hit) begin
            if (under_cnt_q != 16'hFFFF) under_cnt_d = under_cnt_q + 16'd1;
        end else if (clr_cnt) begin
            under_cnt_d = 16'h0;
        end

        if (tick) sample_d = sensor_i;
    end

    assign irq_d = irq_en_q & under_q;

    // State registers with synchronous reset; reset also drops any pending request.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q       <= 1'b0;
            dat_q       <= 32'h0;
            irq_q       <= 1'b0;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            period_q    <= PERIOD_RST;
            thresh_q    <= 12'h0;
            sample_q    <= 24'h0;
            valid_q     <= 1'b0;
            under_q     <= 1'b0;
            under_cnt_q <= 16'h0;
            timer_q     <= PERIOD_RST;
        end else begin
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            irq_q       <= irq_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            period_q    <= period_d;
            thresh_q    <= thresh_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            under_q     <= under_d;
            under_cnt_q <= under_cnt_d;
            timer_q     <= timer_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_solar_wb_regs.sv
// Directed bench for solar_wb_regs. Each bus transfer pushes its expected
// dat_o onto a queue; a monitor on the falling edge pops and compares on
// every ack. Timing and irq checks are made inline by the stimulus.
module tb_solar_wb_regs;

    localparam logic [31:0] A_ID     = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = 32'h3000_0004;
    localparam logic [31:0] A_SAMPLE = 32'h3000_0008;
    localparam logic [31:0] A_THRESH = 32'h3000_000C;
    localparam logic [31:0] A_STATUS = 32'h3000_0010;

    logic        clk;
    logic        rst;
    logic [23:0] sensor;
    logic        irq;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          failures;

    solar_wb_regs_if wbs ();

    solar_wb_regs dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (wbs.slave),
        .sensor_i (sensor),
        .irq_o    (irq)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest expectation.
    always @(negedge clk) begin
        if (wbs.wbs_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got ack with dat 0x%08h expected no ack", wbs.wbs_dat_o);
            end else begin
                chk(name_q.pop_front(), wbs.wbs_dat_o, exp_q.pop_front());
            end
        end
    end

    // Driver: called just after a rising edge; returns just after the ack edge.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp, input string nm,
                           output int lat);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = we;
        wbs.wbs_adr_i = adr;
        wbs.wbs_dat_i = dat;
        wbs.wbs_sel_i = sel;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (wbs.wbs_ack_o !== 1'b1 && lat < 8);
        if (wbs.wbs_ack_o !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no ack after %0d cycles expected ack", nm, lat);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input string nm);
        int lat;
        wb_xfer(1'b1, adr, dat, sel, 32'h0, nm, lat);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string nm);
        int lat;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, exp, nm, lat);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stimulus
    initial begin
        int lat;
        int n;
        int acks;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        sensor   = 24'h0;
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_sel_i = 4'h0;
        wbs.wbs_adr_i = 32'h0;
        wbs.wbs_dat_i = 32'h0;
        cycles(3);
        chk("rst_ack", {31'h0, wbs.wbs_ack_o}, 32'h0);
        chk("rst_dat", wbs.wbs_dat_o, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        cycles(1);

        // Reset register values and ack latency
        wb_xfer(1'b0, A_ID, 32'h0, 4'hF, 32'h534C_5231, "rd_id", lat);
        chk("ack_latency", lat, 32'd1);
        rd(A_CTRL,   32'h03E8_0000, "rd_ctrl_rst");
        rd(A_SAMPLE, 32'h0,         "rd_sample_rst");
        rd(A_THRESH, 32'h0,         "rd_thresh_rst");
        rd(A_STATUS, 32'h0,         "rd_status_rst");

        // First tick lands 5 cycles after enabling with period=4; irq one later
        sensor = 24'h00A123;
        wr(A_THRESH, 32'h0000_0200, 4'hF, "wr_thresh");
        wr(A_CTRL,   32'h0004_0003, 4'hF, "wr_ctrl_en");
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (irq !== 1'b1 && n < 20);
        chk("first_tick_irq_cycles", n, 32'd6);
        wr(A_CTRL,   32'h0004_0002, 4'hF, "wr_ctrl_stop");
        rd(A_STATUS, 32'h0001_0003, "rd_status_tick1");
        rd(A_SAMPLE, 32'h0000_A123, "rd_sample_a123");
        wr(A_STATUS, 32'h0000_0007, 4'hF, "wr_status_clr1");
        cycles(1);
        chk("irq_after_clr1", {31'h0, irq}, 32'h0);

        // Three undervoltage ticks at 12'h1FF, period=4
        sensor = 24'h0001FF;
        wr(A_CTRL, 32'h0004_0003, 4'hF, "wr_ctrl_en2");
        cycles(14);
        rd(A_STATUS, 32'h0002_0003, "rd_status_two_ticks");
        wr(A_CTRL,   32'h0004_0002, 4'hF, "wr_ctrl_stop2");
        rd(A_STATUS, 32'h0003_0003, "rd_status_cnt3");
        chk("irq_cnt3", {31'h0, irq}, 32'h1);

        // Equal to threshold never counts (period=0, tick every cycle)
        sensor = 24'h000200;
        wr(A_CTRL, 32'h0000_0003, 4'hF, "wr_ctrl_p0");
        cycles(5);
        wr(A_CTRL,   32'h0000_0002, 4'hF, "wr_ctrl_p0_stop");
        rd(A_STATUS, 32'h0003_0003, "rd_status_equal");
        rd(A_SAMPLE, 32'h0000_0200, "rd_sample_200");

        // Saturate under_cnt, then clear everything
        wr(A_STATUS, 32'h0000_0007, 4'hF, "wr_status_clr2");
        sensor = 24'h000100;
        wr(A_CTRL, 32'h0000_0003, 4'hF, "wr_ctrl_sat");
        cycles(66000);
        rd(A_STATUS, 32'hFFFF_0003, "rd_status_sat_running");
        wr(A_CTRL,   32'h0000_0002, 4'hF, "wr_ctrl_sat_stop");
        rd(A_STATUS, 32'hFFFF_0003, "rd_status_sat");
        wr(A_STATUS, 32'h0000_0007, 4'hF, "wr_status_clr3");
        chk("irq_hold_after_clr", {31'h0, irq}, 32'h1);
        cycles(1);
        chk("irq_fall_after_clr", {31'h0, irq}, 32'h0);
        rd(A_STATUS, 32'h0, "rd_status_cleared");

        // W1C on a tick edge: under tick wins for valid, under and count
        wr(A_CTRL, 32'h0004_0003, 4'hF, "wr_ctrl_race1");
        cycles(4);
        wr(A_STATUS, 32'h0000_0007, 4'hF, "wr_status_race1");
        wr(A_CTRL,   32'h0004_0002, 4'hF, "wr_ctrl_race1_stop");
        rd(A_STATUS, 32'h0001_0003, "rd_status_race1");

        // W1C on a non-under tick: valid kept, under and count cleared
        sensor = 24'h000300;
        wr(A_CTRL, 32'h0004_0003, 4'hF, "wr_ctrl_race2");
        cycles(4);
        wr(A_STATUS, 32'h0000_0007, 4'hF, "wr_status_race2");
        wr(A_CTRL,   32'h0004_0002, 4'hF, "wr_ctrl_race2_stop");
        rd(A_STATUS, 32'h0000_0001, "rd_status_race2");

        // Byte-lane write: only the period lanes change
        wr(A_CTRL, 32'h1234_FFFF, 4'b1100, "wr_ctrl_bytes");
        rd(A_CTRL, 32'h1234_0002, "rd_ctrl_bytes");

        // Out-of-window request never acks
        acks = 0;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_adr_i = 32'h3000_0100;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (wbs.wbs_ack_o === 1'b1) acks++;
        end
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        chk("out_of_window_acks", acks, 32'd0);

        // Unmapped in-window offset acks and reads zero; writes ignored
        wr(32'h3000_003C, 32'hFFFF_FFFF, 4'hF, "wr_unmapped");
        rd(32'h3000_003C, 32'h0, "rd_unmapped");

        // Reset while a write is pending: no ack, nothing committed
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = 1'b1;
        wbs.wbs_sel_i = 4'hF;
        wbs.wbs_adr_i = A_THRESH;
        wbs.wbs_dat_i = 32'h0000_0ABC;
        rst = 1'b1;
        cycles(1);
        chk("rst_pending_ack", {31'h0, wbs.wbs_ack_o}, 32'h0);
        chk("rst_pending_dat", wbs.wbs_dat_o, 32'h0);
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        rst = 1'b0;
        cycles(1);
        rd(A_THRESH, 32'h0,         "rd_thresh_after_rst");
        rd(A_CTRL,   32'h03E8_0000, "rd_ctrl_after_rst");

        cycles(2);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
